spi_peripheral: RTL and testbench

SPI mode-0 peripheral (responder), MSB first, 8-bit frames. It is the far end of the team's SPI controller: it receives bytes on COPI and returns bytes on CIPO. All SPI pins are oversampled and synchronised into the local system clock. Received bytes are presented with a one-cycle data-valid pulse, and transmit bytes are supplied through a one-deep ready/valid holding register.

---
 rtl/spi_peripheral.sv | 162 ++++++++++++++++
 tb/tb_spi_peripheral.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder, MSB first, 8-bit frames; SPI pins oversampled into i_clk.
// RX bytes pop out with a one-cycle valid pulse; TX bytes come from a one-deep holding register.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_copi,
  output logic       o_spi_cipo,
  output logic       o_spi_cipo_oe
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_copi_sync, r_vld_sync;
  logic                   r_sclk_prev, r_cs_prev, r_armed;

  logic [7:0] r_hold, r_tx_shift, r_rx_shift, r_rx_byte;
  logic       r_hold_vld, r_rx_dv, r_cipo, r_oe;
  logic [2:0] r_bit_cnt;

  logic       w_sclk, w_cs, w_copi;
  logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic       w_enter, w_leave, w_act_rise, w_act_fall, w_load;
  logic [7:0] w_next_byte, w_rx_next;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_copi = r_copi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_cs_rise   = w_cs & ~r_cs_prev;
  assign w_cs_fall   = ~w_cs & r_cs_prev;

  // r_vld_sync marks when the synchroniser output reflects the pin rather than
  // its reset value, so a cs_n held low through reset cannot arm the block.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_copi_sync <= '0;
      r_vld_sync  <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], i_spi_copi};
      r_vld_sync  <= {r_vld_sync[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs;
      r_armed     <= r_armed | (r_vld_sync[SYNC_STAGES-1] & w_cs);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_leave     = 1'b0;
    w_act_rise  = 1'b0;
    w_act_fall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall && r_armed) begin
          w_state_nxt = S_ACTIVE;
          w_enter     = 1'b1;
        end
      end
      S_ACTIVE: begin
        // cs_n rise wins over any SCLK edge seen in the same cycle
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_leave     = 1'b1;
        end else begin
          w_act_rise = w_sclk_rise;
          w_act_fall = w_sclk_fall;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load      = w_enter | (w_act_fall & (r_bit_cnt == 3'd0));
  assign w_next_byte = r_hold_vld ? r_hold : 8'h00;
  assign w_rx_next   = {r_rx_shift[6:0], w_copi};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold     <= 8'h00;
      r_hold_vld <= 1'b0;
      r_tx_shift <= 8'h00;
      r_rx_shift <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_dv    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_cipo     <= 1'b0;
      r_oe       <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;

      if (w_load && r_hold_vld) begin
        r_hold_vld <= 1'b0;
      end else if (i_tx_dv && !r_hold_vld) begin
        r_hold     <= i_tx_byte;
        r_hold_vld <= 1'b1;
      end

      if (w_enter) begin
        r_tx_shift <= w_next_byte;
        r_cipo     <= w_next_byte[7];
        r_oe       <= 1'b1;
        r_bit_cnt  <= 3'd0;
      end else if (w_leave) begin
        r_rx_shift <= 8'h00;
        r_bit_cnt  <= 3'd0;
        r_cipo     <= 1'b0;
        r_oe       <= 1'b0;
      end else begin
        if (w_act_rise) begin
          r_rx_shift <= w_rx_next;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_rx_byte <= w_rx_next;
            r_rx_dv   <= 1'b1;
          end
        end
        if (w_act_fall) begin
          if (r_bit_cnt == 3'd0) begin
            r_tx_shift <= w_next_byte;
            r_cipo     <= w_next_byte[7];
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_cipo     <= r_tx_shift[6];
          end
        end
      end
    end
  end

  assign o_tx_ready    = ~r_hold_vld;
  assign o_rx_byte     = r_rx_byte;
  assign o_rx_dv       = r_rx_dv;
  assign o_spi_cipo    = r_cipo;
  assign o_spi_cipo_oe = r_oe;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as a slow SPI controller (half-period 4 i_clk).
module tb_spi_peripheral;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_tx_byte;
  logic       i_tx_dv;
  logic       o_tx_ready;
  logic [7:0] o_rx_byte;
  logic       o_rx_dv;
  logic       i_spi_clk;
  logic       i_spi_cs_n;
  logic       i_spi_copi;
  logic       o_spi_cipo;
  logic       o_spi_cipo_oe;

  int n_chk = 0;
  int n_err = 0;
  int rx_cnt = 0;
  logic [7:0] rx_log [0:31];
  logic [7:0] cap;

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_tx_byte     (i_tx_byte),
    .i_tx_dv       (i_tx_dv),
    .o_tx_ready    (o_tx_ready),
    .o_rx_byte     (o_rx_byte),
    .o_rx_dv       (o_rx_dv),
    .i_spi_clk     (i_spi_clk),
    .i_spi_cs_n    (i_spi_cs_n),
    .i_spi_copi    (i_spi_copi),
    .o_spi_cipo    (o_spi_cipo),
    .o_spi_cipo_oe (o_spi_cipo_oe)
  );

  always #5 i_clk = ~i_clk;

  // every rx_dv pulse is logged; a pulse longer than one cycle logs twice
  always @(negedge i_clk) begin
    if (o_rx_dv) begin
      if (rx_cnt < 32) rx_log[rx_cnt] = o_rx_byte;
      rx_cnt = rx_cnt + 1;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    i_tx_byte = b;
    i_tx_dv   = 1'b1;
    tick(1);
    i_tx_dv   = 1'b0;
  endtask

  // one SCLK period; CIPO is captured just before the rise, as a controller would
  task automatic sclk_bit(input logic b);
    i_spi_copi = b;
    tick(4);
    cap = {cap[6:0], o_spi_cipo};
    i_spi_clk = 1'b1;
    tick(4);
    i_spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    for (int i = 7; i >= 0; i--) sclk_bit(tx[i]);
  endtask

  initial begin
    logic oe_any;
    int   base;

    i_reset    = 1'b1;
    i_tx_byte  = 8'h00;
    i_tx_dv    = 1'b0;
    i_spi_clk  = 1'b0;
    i_spi_cs_n = 1'b0;
    i_spi_copi = 1'b0;
    tick(3);
    chk("rst_tx_ready", 8'(o_tx_ready), 8'd1);
    chk("rst_rx_byte", o_rx_byte, 8'h00);
    chk("rst_rx_dv", 8'(o_rx_dv), 8'd0);
    chk("rst_cipo", 8'(o_spi_cipo), 8'd0);
    chk("rst_oe", 8'(o_spi_cipo_oe), 8'd0);

    // cs_n held low through reset: SCLK activity must not start a frame
    i_reset = 1'b0;
    oe_any  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_spi_copi = i[0];
      for (int k = 0; k < 4; k++) begin tick(1); oe_any |= o_spi_cipo_oe; end
      i_spi_clk = 1'b1;
      for (int k = 0; k < 4; k++) begin tick(1); oe_any |= o_spi_cipo_oe; end
      i_spi_clk = 1'b0;
    end
    tick(4);
    chk("unarmed_rx_cnt", 8'(rx_cnt), 8'd0);
    chk("unarmed_oe", 8'(oe_any), 8'd0);

    // arm, preload A5, single byte
    i_spi_cs_n = 1'b1;
    tick(6);
    load_tx(8'hA5);
    chk("preload_ready", 8'(o_tx_ready), 8'd0);
    i_spi_cs_n = 1'b0;
    spi_byte(8'h3C);
    i_spi_cs_n = 1'b1;
    chk("b1_cipo", cap, 8'hA5);
    chk("b1_rx_cnt", 8'(rx_cnt), 8'd1);
    chk("b1_rx_byte", rx_log[0], 8'h3C);
    chk("b1_ready", 8'(o_tx_ready), 8'd1);
    tick(6);
    chk("b1_end_oe", 8'(o_spi_cipo_oe), 8'd0);
    chk("b1_end_cipo", 8'(o_spi_cipo), 8'd0);

    // three-byte frame: 11 preloaded, 22 reloaded between bytes, 33 offered mid-byte 3
    load_tx(8'h11);
    i_spi_cs_n = 1'b0;
    spi_byte(8'h01);
    chk("f3_b0_cipo", cap, 8'h11);
    load_tx(8'h22);
    spi_byte(8'h80);
    chk("f3_b1_cipo", cap, 8'h22);
    for (int i = 7; i >= 4; i--) sclk_bit(1'b1);
    load_tx(8'h33);
    chk("f3_late_ready", 8'(o_tx_ready), 8'd0);
    for (int i = 3; i >= 0; i--) sclk_bit(1'b1);
    // final SCLK fall and cs_n rise together: the rise wins, 33 stays held
    i_spi_cs_n = 1'b1;
    chk("f3_b2_cipo", cap, 8'h00);
    tick(6);
    chk("f3_rx_cnt", 8'(rx_cnt), 8'd4);
    chk("f3_rx0", rx_log[1], 8'h01);
    chk("f3_rx1", rx_log[2], 8'h80);
    chk("f3_rx2", rx_log[3], 8'hFF);
    chk("f3_hold_kept", 8'(o_tx_ready), 8'd0);

    i_spi_cs_n = 1'b0;
    spi_byte(8'h5A);
    i_spi_cs_n = 1'b1;
    chk("kept_cipo", cap, 8'h33);
    chk("kept_rx", rx_log[4], 8'h5A);
    tick(6);

    // load while full is ignored
    load_tx(8'h55);
    load_tx(8'h77);
    chk("full_ready", 8'(o_tx_ready), 8'd0);
    i_spi_cs_n = 1'b0;
    spi_byte(8'hE7);
    i_spi_cs_n = 1'b1;
    chk("full_cipo", cap, 8'h55);
    chk("full_rx", rx_log[5], 8'hE7);
    tick(6);

    // abort after five SCLK rises, then a fresh full byte
    base = rx_cnt;
    i_spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) sclk_bit(1'b1);
    i_spi_cs_n = 1'b1;
    tick(6);
    chk("abort_rx_cnt", 8'(rx_cnt - base), 8'd0);
    chk("abort_oe", 8'(o_spi_cipo_oe), 8'd0);
    chk("abort_cipo", 8'(o_spi_cipo), 8'd0);
    i_spi_cs_n = 1'b0;
    spi_byte(8'hC3);
    i_spi_cs_n = 1'b1;
    chk("post_abort_cnt", 8'(rx_cnt - base), 8'd1);
    chk("post_abort_rx", rx_log[6], 8'hC3);
    chk("post_abort_cipo", cap, 8'h00);
    tick(6);

    // reset mid-byte with the holding register full
    load_tx(8'h9A);
    i_spi_cs_n = 1'b0;
    tick(6);
    load_tx(8'h5E);
    for (int i = 0; i < 3; i++) sclk_bit(1'b0);
    i_spi_clk = 1'b1;
    tick(2);
    chk("pre_rst_oe", 8'(o_spi_cipo_oe), 8'd1);
    chk("pre_rst_ready", 8'(o_tx_ready), 8'd0);
    chk("pre_rst_rx_byte", o_rx_byte, 8'hC3);
    i_reset = 1'b1;
    tick(1);
    chk("mid_rst_ready", 8'(o_tx_ready), 8'd1);
    chk("mid_rst_rx_byte", o_rx_byte, 8'h00);
    chk("mid_rst_rx_dv", 8'(o_rx_dv), 8'd0);
    chk("mid_rst_cipo", 8'(o_spi_cipo), 8'd0);
    chk("mid_rst_oe", 8'(o_spi_cipo_oe), 8'd0);
    i_reset    = 1'b0;
    i_spi_clk  = 1'b0;
    i_spi_cs_n = 1'b1;
    tick(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
